// File: rtl/alu_logic_operand_seq_if.sv
// Bus bundle between the operand sequencer, the MCU data bus, the bitwise
// logic unit and the downstream result consumer.
//   in_data/in_valid/in_ready        : two-beat operand bus (A then B)
//   opa/opb/lu_res                   : operands to and result from the logic unit
//   result/zero/ones/out_valid/out_ready : registered result with flags
//   op_count                         : completed-operation debug counter
// slave  : view used by the sequencer
// master : view used by whatever drives the bus and the logic unit
interface alu_logic_operand_seq_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 8
) ();
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] lu_res;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             ones;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] op_count;

    modport slave (
        input  in_data, in_valid, lu_res, out_ready,
        output in_ready, opa, opb, result, zero, ones, out_valid, op_count
    );

    modport master (
        output in_data, in_valid, lu_res, out_ready,
        input  in_ready, opa, opb, result, zero, ones, out_valid, op_count
    );
endinterface

// File: rtl/alu_logic_operand_seq.sv
// Operand sequencer for the 16-bit bitwise logic unit.
// Collects A then B from the data bus, holds them stable to the logic unit,
// registers the unit's result with ZERO/ONES flags and hands it downstream.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   clr   : synchronous abort back to idle (beats in flight are dropped)
//   bus   : slave view of alu_logic_operand_seq_if (see interface header)
module alu_logic_operand_seq #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    alu_logic_operand_seq_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GOT_A = 2'd1,
        ST_EXEC  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e           state_q,     state_d;
    logic             in_ready_q,  in_ready_d;
    logic [WIDTH-1:0] opa_q,       opa_d;
    logic [WIDTH-1:0] opb_q,       opb_d;
    logic [WIDTH-1:0] result_q,    result_d;
    logic             zero_q,      zero_d;
    logic             ones_q,      ones_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] op_count_q,  op_count_d;

    // Next-state and datapath; clr overrides any transfer in the same cycle.
    always_comb begin
        state_d     = state_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        result_d    = result_q;
        zero_d      = zero_q;
        ones_d      = ones_q;
        out_valid_d = out_valid_q;
        op_count_d  = op_count_q;

        if (clr) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        opa_d   = bus.in_data;
                        state_d = ST_GOT_A;
                    end
                end
                ST_GOT_A: begin
                    if (bus.in_valid && in_ready_q) begin
                        opb_d   = bus.in_data;
                        state_d = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    result_d    = bus.lu_res;
                    zero_d      = (bus.lu_res == '0);
                    ones_d      = &bus.lu_res;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
                ST_DONE: begin
                    if (bus.out_ready && out_valid_q) begin
                        out_valid_d = 1'b0;
                        op_count_d  = op_count_q + CNT_W'(1);
                        state_d     = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Registered copy of the state decode so in_ready is a flop output.
        in_ready_d = (state_d == ST_IDLE) || (state_d == ST_GOT_A);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            opa_q       <= '0;
            opb_q       <= '0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            ones_q      <= 1'b0;
            out_valid_q <= 1'b0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            ones_q      <= ones_d;
            out_valid_q <= out_valid_d;
            op_count_q  <= op_count_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.opa       = opa_q;
    assign bus.opb       = opb_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.ones      = ones_q;
    assign bus.out_valid = out_valid_q;
    assign bus.op_count  = op_count_q;

endmodule

// File: tb/tb_alu_logic_operand_seq.sv
// Self-checking bench for alu_logic_operand_seq with an XNOR logic unit.
module tb_alu_logic_operand_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    alu_logic_operand_seq_if bus ();

    // POS_XNOR logic unit
    assign bus.lu_res = ~(bus.opa ^ bus.opb);

    alu_logic_operand_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad   = 0;
    int exp_count = 0;

    int unsigned cyc = 0;
    int unsigned beat_cyc[$];
    logic [15:0] out_q[$];

    // Record cycle numbers of accepted input beats and accepted results.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && !clr && bus.in_valid && bus.in_ready) beat_cyc.push_back(cyc);
        if (rst_n && !clr && bus.out_valid && bus.out_ready) out_q.push_back(bus.result);
    end

    function automatic logic [15:0] ref_res(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = (a[i] == b[i]);
        return r;
    endfunction

    // Offer one beat; called at a negedge, returns at a negedge with in_valid low.
    task automatic push(input logic [15:0] d, output bit ok);
        int n = 0;
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = (n < 50);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = 16'($urandom);
    endtask

    // Issue A and B, return at the first negedge with out_valid high.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, output bit ok);
        bit ok_a, ok_b;
        int n = 0;
        push(a, ok_a);
        push(b, ok_b);
        while (bus.out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok = ok_a && ok_b && (n < 20);
    endtask

    task automatic accept();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        exp_count = (exp_count + 1) % 256;
    endtask

    task automatic test_reset();
        total++; if (bus.opa !== 16'h0)    begin bad++; $display("FAIL rst_opa got=%h exp=0", bus.opa); end
        total++; if (bus.opb !== 16'h0)    begin bad++; $display("FAIL rst_opb got=%h exp=0", bus.opb); end
        total++; if (bus.result !== 16'h0) begin bad++; $display("FAIL rst_result got=%h exp=0", bus.result); end
        total++; if (bus.zero !== 1'b0)    begin bad++; $display("FAIL rst_zero got=%b exp=0", bus.zero); end
        total++; if (bus.ones !== 1'b0)    begin bad++; $display("FAIL rst_ones got=%b exp=0", bus.ones); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
        total++; if (bus.op_count !== 8'h0) begin bad++; $display("FAIL rst_op_count got=%0d exp=0", bus.op_count); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", bus.in_ready); end
    endtask

    task automatic test_basic();
        bit ok;
        do_op(16'h0000, 16'h68AF, ok);
        total++; if (!ok) begin bad++; $display("FAIL basic_timeout got=0 exp=1"); end
        total++; if (bus.result !== 16'h9750) begin bad++; $display("FAIL basic_result got=%h exp=9750", bus.result); end
        total++; if (bus.zero !== 1'b0) begin bad++; $display("FAIL basic_zero got=%b exp=0", bus.zero); end
        total++; if (bus.ones !== 1'b0) begin bad++; $display("FAIL basic_ones got=%b exp=0", bus.ones); end
        accept();
        total++; if (bus.op_count !== 8'(exp_count)) begin bad++; $display("FAIL basic_count got=%0d exp=%0d", bus.op_count, exp_count); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int n = 0;
        beat_cyc.delete();
        out_q.delete();
        bus.out_ready = 1'b1;
        push(16'hFFFF, ok);
        push(16'hFF55, ok);
        push(16'h0000, ok);
        push(16'hCCCC, ok);
        while (out_q.size() < 2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        bus.out_ready = 1'b0;
        exp_count = (exp_count + 2) % 256;
        total++; if (out_q.size() != 2 || beat_cyc.size() != 4) begin
            bad++; $display("FAIL b2b_counts got=%0d/%0d exp=2/4", out_q.size(), beat_cyc.size());
        end else begin
            total++; if (out_q[0] !== ref_res(16'hFFFF, 16'hFF55)) begin bad++; $display("FAIL b2b_res0 got=%h exp=ff55", out_q[0]); end
            total++; if (out_q[1] !== ref_res(16'h0000, 16'hCCCC)) begin bad++; $display("FAIL b2b_res1 got=%h exp=3333", out_q[1]); end
            total++; if (beat_cyc[2] - beat_cyc[0] != 4) begin bad++; $display("FAIL b2b_interval_a got=%0d exp=4", beat_cyc[2] - beat_cyc[0]); end
            total++; if (beat_cyc[1] - beat_cyc[0] != 1) begin bad++; $display("FAIL b2b_ab_gap got=%0d exp=1", beat_cyc[1] - beat_cyc[0]); end
        end
        total++; if (bus.op_count !== 8'(exp_count)) begin bad++; $display("FAIL b2b_count got=%0d exp=%0d", bus.op_count, exp_count); end
    endtask

    task automatic test_flags();
        bit ok;
        do_op(16'hFFFF, 16'h0000, ok);
        total++; if (!ok || bus.result !== 16'h0000 || bus.zero !== 1'b1 || bus.ones !== 1'b0) begin
            bad++; $display("FAIL flags_zero got=%h z=%b o=%b exp=0000 z=1 o=0", bus.result, bus.zero, bus.ones);
        end
        accept();
        do_op(16'h1234, 16'h1234, ok);
        total++; if (!ok || bus.result !== 16'hFFFF || bus.zero !== 1'b0 || bus.ones !== 1'b1) begin
            bad++; $display("FAIL flags_ones got=%h z=%b o=%b exp=ffff z=0 o=1", bus.result, bus.zero, bus.ones);
        end
        accept();
    endtask

    task automatic test_backpressure();
        bit ok;
        int nb;
        logic [15:0] a, b, r;
        a = 16'($urandom); b = 16'($urandom); r = ref_res(a, b);
        do_op(a, b, ok);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'($urandom);
        nb = beat_cyc.size();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++; if (bus.out_valid !== 1'b1 || bus.result !== r || bus.in_ready !== 1'b0) begin
                bad++; $display("FAIL bp_hold%0d got=v%b r=%h ir=%b exp=v1 r=%h ir=0", i, bus.out_valid, bus.result, bus.in_ready, r);
            end
        end
        bus.in_valid = 1'b0;
        total++; if (beat_cyc.size() != nb) begin bad++; $display("FAIL bp_no_beat got=%0d exp=%0d", beat_cyc.size(), nb); end
        accept();
        total++; if (bus.op_count !== 8'(exp_count) || bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL bp_release got=%0d v=%b exp=%0d v=0", bus.op_count, bus.out_valid, exp_count);
        end
    endtask

    task automatic test_clr();
        bit ok;
        logic [15:0] prev;
        // abort with A held in GOT_A
        push(16'hAAAA, ok);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        total++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            bad++; $display("FAIL clr_idle got=ir%b v%b exp=ir1 v0", bus.in_ready, bus.out_valid);
        end
        do_op(16'h0F0F, 16'h0F0F, ok);
        total++; if (!ok || bus.result !== 16'hFFFF || bus.ones !== 1'b1) begin
            bad++; $display("FAIL clr_after got=%h o=%b exp=ffff o=1", bus.result, bus.ones);
        end
        accept();
        // clr beats a same-cycle B beat
        push(16'h1111, ok);
        clr = 1'b1; bus.in_valid = 1'b1; bus.in_data = 16'h2222;
        @(negedge clk);
        clr = 1'b0; bus.in_valid = 1'b0;
        do_op(16'h5555, 16'hAAAA, ok);
        total++; if (!ok || bus.result !== 16'h0000 || bus.zero !== 1'b1) begin
            bad++; $display("FAIL clr_beat got=%h z=%b exp=0000 z=1", bus.result, bus.zero);
        end
        accept();
        // clr beats a same-cycle output transfer
        do_op(16'h00FF, 16'h0F0F, ok);
        prev = ref_res(16'h00FF, 16'h0F0F);
        clr = 1'b1; bus.out_ready = 1'b1;
        @(negedge clk);
        clr = 1'b0; bus.out_ready = 1'b0;
        total++; if (bus.out_valid !== 1'b0 || bus.op_count !== 8'(exp_count) || bus.result !== prev) begin
            bad++; $display("FAIL clr_done got=v%b c=%0d r=%h exp=v0 c=%0d r=%h", bus.out_valid, bus.op_count, bus.result, exp_count, prev);
        end
        // clr during EXEC leaves the old result in place
        push(16'h1234, ok);
        push(16'h4321, ok);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        total++; if (bus.out_valid !== 1'b0 || bus.result !== prev || bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL clr_exec got=v%b r=%h ir=%b exp=v0 r=%h ir=1", bus.out_valid, bus.result, bus.in_ready, prev);
        end
    endtask

    task automatic test_random();
        bit ok_a, ok_b;
        logic [15:0] a, b, r;
        int n;
        for (int i = 0; i < 20; i++) begin
            a = 16'($urandom); b = 16'($urandom); r = ref_res(a, b);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            push(a, ok_a);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            push(b, ok_b);
            n = 0;
            while (bus.out_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            total++; if (!ok_a || !ok_b || n >= 20 || bus.result !== r || bus.zero !== (r == 16'h0) || bus.ones !== (r == 16'hFFFF)) begin
                bad++; $display("FAIL rand%0d got=%h z=%b o=%b exp=%h", i, bus.result, bus.zero, bus.ones, r);
            end
            accept();
        end
        total++; if (bus.op_count !== 8'(exp_count)) begin bad++; $display("FAIL rand_count got=%0d exp=%0d", bus.op_count, exp_count); end
    endtask

    task automatic test_reset_mid_exec();
        bit ok;
        push(16'h0F00, ok);
        push(16'h00F0, ok);
        #2 rst_n = 1'b0;
        #1;
        total++; if (bus.opa !== 16'h0 || bus.opb !== 16'h0 || bus.result !== 16'h0 || bus.zero !== 1'b0 ||
                     bus.ones !== 1'b0 || bus.out_valid !== 1'b0 || bus.op_count !== 8'h0 || bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL async_rst got=a%h b%h r%h z%b o%b v%b c%0d ir%b exp=all0 ir1",
                            bus.opa, bus.opb, bus.result, bus.zero, bus.ones, bus.out_valid, bus.op_count, bus.in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_count = 0;
        @(negedge clk);
    endtask

    task automatic test_wrap();
        bit ok;
        logic [15:0] a, b, r;
        for (int i = 0; i < 256; i++) begin
            a = 16'($urandom); b = 16'($urandom); r = ref_res(a, b);
            do_op(a, b, ok);
            total++; if (!ok || bus.result !== r) begin bad++; $display("FAIL wrap_op%0d got=%h exp=%h", i, bus.result, r); end
            accept();
            if (i == 254) begin
                total++; if (bus.op_count !== 8'd255) begin bad++; $display("FAIL wrap_255 got=%0d exp=255", bus.op_count); end
            end
        end
        total++; if (bus.op_count !== 8'(exp_count) || exp_count != 0) begin
            bad++; $display("FAIL wrap_zero got=%0d exp=0", bus.op_count);
        end
    endtask

    initial begin
        bus.in_data   = 16'h0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_basic();
        test_back_to_back();
        test_flags();
        test_backpressure();
        test_clr();
        test_random();
        test_reset_mid_exec();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
